emu_host_master: RTL

- Host-side master for the co-emulation wrapper interface. It drives Din_emu/Addr_emu/load_emu/get_emu/clk_emu/clk_dut and reads Dout_emu.
- A byte stream from the host link (UART/MCU bridge) carries stimulus vectors in. Captured DUT output vectors go back out on a second byte stream.
- One stimulus vector in produces one DUT clock and one output vector out.
- Sits in the FPGA/MCU side of the emulation rig, directly facing the wrapper.

---
 rtl/emu_pkg.sv | 19 +
 rtl/emu_clk_pulser.sv | 81 ++++++++
 rtl/emu_host_master.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/emu_pkg.sv
// Shared state encoding and default sizing for the co-emulation host master.
package emu_pkg;

    typedef enum logic [2:0] {
        ST_RX_WAIT = 3'd0,
        ST_WR      = 3'd1,
        ST_LOAD    = 3'd2,
        ST_DUT     = 3'd3,
        ST_GET     = 3'd4,
        ST_RD      = 3'd5,
        ST_TX      = 3'd6
    } emu_state_e;

    localparam int DEF_NUM_STIM = 3;
    localparam int DEF_NUM_OUT  = 2;
    localparam int DEF_EMU_DIV  = 2;
    localparam int DEF_ADDR_W   = 3;

endpackage

// File: rtl/emu_clk_pulser.sv
// Generates one clk_emu or clk_dut pulse per start: EMU_DIV cycles low, EMU_DIV high, then fall.
// done is high during the last high cycle, so the clock falls on the same edge the FSM advances,
// and a start presented with done chains the next pulse with no idle gap.
module emu_clk_pulser
    import emu_pkg::*;
#(
    parameter int EMU_DIV = DEF_EMU_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic sel,
    output logic clk_emu,
    output logic clk_dut,
    output logic done
);

    localparam logic [7:0] PHASE_TC = 8'(EMU_DIV - 1);

    logic       active_q, active_d;
    logic       high_q, high_d;
    logic       sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic       clk_emu_q, clk_emu_d;
    logic       clk_dut_q, clk_dut_d;

    assign done    = active_q && high_q && (cnt_q == 8'd0);
    assign clk_emu = clk_emu_q;
    assign clk_dut = clk_dut_q;

    // Phase down-counter: terminal count flips low->high, then high->idle (or restart).
    always_comb begin
        active_d  = active_q;
        high_d    = high_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        clk_emu_d = clk_emu_q;
        clk_dut_d = clk_dut_q;
        if (active_q) begin
            if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else if (!high_q) begin
                high_d    = 1'b1;
                cnt_d     = PHASE_TC;
                clk_emu_d = !sel_q;
                clk_dut_d = sel_q;
            end else begin
                high_d    = 1'b0;
                active_d  = 1'b0;
                clk_emu_d = 1'b0;
                clk_dut_d = 1'b0;
            end
        end
        if (start && (!active_q || done)) begin
            active_d = 1'b1;
            high_d   = 1'b0;
            sel_d    = sel;
            cnt_d    = PHASE_TC;
        end
    end

    // Pulse state registers; clocks drop immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            high_q    <= 1'b0;
            sel_q     <= 1'b0;
            cnt_q     <= 8'd0;
            clk_emu_q <= 1'b0;
            clk_dut_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            high_q    <= high_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            clk_emu_q <= clk_emu_d;
            clk_dut_q <= clk_dut_d;
        end
    end

endmodule

// File: rtl/emu_host_master.sv
// Host-side master for the co-emulation wrapper: stimulus bytes in, one DUT clock, output bytes out.
//
// state    | meaning
// RX_WAIT  | s_ready high, waiting for next stimulus byte
// WR       | clk_emu pulse writing Din_emu into stimIn[Addr_emu]
// LOAD     | clk_emu pulse with load_emu=1 (stimIn -> DUT inputs)
// DUT      | single clk_dut pulse
// GET      | clk_emu pulse with get_emu=1 (DUT outputs -> vectOut)
// RD       | clk_emu pulse reading vectOut[Addr_emu] into Dout_emu
// TX       | m_valid held until host takes m_data
module emu_host_master
    import emu_pkg::*;
#(
    parameter int NUM_STIM = DEF_NUM_STIM,
    parameter int NUM_OUT  = DEF_NUM_OUT,
    parameter int EMU_DIV  = DEF_EMU_DIV,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        Din_emu,
    input  logic [7:0]        Dout_emu,
    output logic [ADDR_W-1:0] Addr_emu,
    output logic              load_emu,
    output logic              get_emu,
    output logic              clk_emu,
    output logic              clk_dut,
    output logic              busy,
    output logic [15:0]       vec_count
);

    localparam logic [ADDR_W-1:0] STIM_LAST = ADDR_W'(NUM_STIM - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST  = ADDR_W'(NUM_OUT - 1);

    emu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              load_q, load_d;
    logic              get_q, get_d;
    logic              s_ready_q, s_ready_d;
    logic [7:0]        m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic [15:0]       vec_q, vec_d;
    logic              pend_q, pend_d;

    logic pulse_start;
    logic pulse_sel;
    logic pulse_done;

    emu_clk_pulser #(
        .EMU_DIV (EMU_DIV)
    ) u_pulser (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (pulse_start),
        .sel     (pulse_sel),
        .clk_emu (clk_emu),
        .clk_dut (clk_dut),
        .done    (pulse_done)
    );

    assign s_ready   = s_ready_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign Din_emu   = din_q;
    assign Addr_emu  = addr_q;
    assign load_emu  = load_q;
    assign get_emu   = get_q;
    assign vec_count = vec_q;
    assign busy      = (state_q != ST_RX_WAIT) || (idx_q != '0);

    // Next-state logic. Wrapper-facing outputs only change on a pulse fall or while idle-low.
    // pend_q gives a freshly set address one setup cycle before the pulse that follows
    // an accepted byte or a host handshake; pulses inside a vector are chained on done.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        din_d       = din_q;
        load_d      = load_q;
        get_d       = get_q;
        s_ready_d   = s_ready_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        vec_d       = vec_q;
        pend_d      = 1'b0;
        pulse_start = pend_q;
        pulse_sel   = 1'b0;
        unique case (state_q)
            ST_RX_WAIT: begin
                if (s_valid && s_ready_q) begin
                    din_d     = s_data;
                    addr_d    = idx_q;
                    s_ready_d = 1'b0;
                    pend_d    = 1'b1;
                    state_d   = ST_WR;
                end else begin
                    s_ready_d = 1'b1;
                end
            end
            ST_WR: begin
                if (pulse_done) begin
                    if (idx_q < STIM_LAST) begin
                        idx_d     = idx_q + 1'b1;
                        s_ready_d = 1'b1;
                        state_d   = ST_RX_WAIT;
                    end else begin
                        load_d      = 1'b1;
                        pulse_start = 1'b1;
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (pulse_done) begin
                    load_d      = 1'b0;
                    pulse_start = 1'b1;
                    pulse_sel   = 1'b1;
                    state_d     = ST_DUT;
                end
            end
            ST_DUT: begin
                if (pulse_done) begin
                    get_d       = 1'b1;
                    pulse_start = 1'b1;
                    state_d     = ST_GET;
                end
            end
            ST_GET: begin
                if (pulse_done) begin
                    get_d       = 1'b0;
                    addr_d      = '0;
                    din_d       = 8'h00;
                    pulse_start = 1'b1;
                    state_d     = ST_RD;
                end
            end
            ST_RD: begin
                if (pulse_done) begin
                    m_data_d  = Dout_emu;
                    m_valid_d = 1'b1;
                    state_d   = ST_TX;
                end
            end
            ST_TX: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (addr_q < OUT_LAST) begin
                        addr_d  = addr_q + 1'b1;
                        pend_d  = 1'b1;
                        state_d = ST_RD;
                    end else begin
                        vec_d     = vec_q + 16'd1;
                        idx_d     = '0;
                        addr_d    = '0;
                        s_ready_d = 1'b1;
                        state_d   = ST_RX_WAIT;
                    end
                end
            end
            default: state_d = ST_RX_WAIT;
        endcase
    end

    // FSM and registered output flops; reset aborts any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RX_WAIT;
            idx_q     <= '0;
            addr_q    <= '0;
            din_q     <= 8'h00;
            load_q    <= 1'b0;
            get_q     <= 1'b0;
            s_ready_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            vec_q     <= 16'd0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            load_q    <= load_d;
            get_q     <= get_d;
            s_ready_q <= s_ready_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            vec_q     <= vec_d;
            pend_q    <= pend_d;
        end
    end

endmodule
